adder_error_monitor: RTL
========================

# adder_error_monitor

Synthesizable, streaming error-metric engine for approximate adders of width N. It compares each approximate sum against the exact sum and accumulates error count, total error distance and maximum error distance over a programmed number of samples. It sits beside a device-under-test adder, on-chip or in emulation, and replaces software-only characterisation with cycle-accurate hardware counters. Host logic derives ER, MED and NMED from the final registers.

## Interface
- N, 16, operand/sum width in bits
- CNT_W, 32, width of sample and error counters
- ACC_W, 48, width of the error-distance accumulator (must be ≥ N)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
- num_samples  in  CNT_W  samples per run, sampled on accepted start
- in_valid  in  1  sample pair present
- in_ready  out  1  engine accepts sample this cycle
- approx_sum  in  N  approximate adder output
- exact_sum  in  N  reference sum (mod 2^N)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when results final
- sample_count  out  CNT_W  samples accepted in current/last run
- err_count  out  CNT_W  samples with approx_sum ≠ exact_sum
- sum_ed  out  ACC_W  Σ|approx_sum − exact_sum|, saturating
- max_ed  out  N  largest |approx_sum − exact_sum| seen
- ovf  out  1  sticky: sum_ed saturated during run

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. On start: latch num_samples; clear sample_count, err_count, sum_ed, max_ed, ovf (and bias_sum); go RUN. If latched num_samples=0, go DRAIN instead.
- RUN: in_ready=1 while sample_count < latched num_samples. Transfer = in_valid & in_ready; each transfer increments sample_count. Transfer that makes sample_count equal to num_samples → DRAIN next cycle; in_ready drops the same cycle.
- Pipeline stage 1 (transfer cycle +1): register ed = |approx_sum − exact_sum| as unsigned N-bit magnitude (compare, then subtract larger minus smaller; no wrap-around) and mismatch flag.
- Stage 2 (+2): err_count += mismatch; sum_ed += ed, clamped to 2^ACC_W−1, ovf set on clamp; max_ed = max(max_ed, ed).
- DRAIN: wait exactly 2 cycles for pipeline empty, then DONE.
- DONE: done=1 for one cycle; go IDLE. All result outputs hold until next accepted start.
- start while busy or in DONE: ignored.
- err_count cannot overflow (bounded by sample_count).
- rst_n=0 at any clock edge, including mid-run: state→IDLE, pipeline valids cleared, in-flight samples discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, all counters/accumulators/max_ed=0, ovf=0.
- Start accepted at edge T → busy=1 and in_ready=1 from T+1.
- Sample accepted at edge T contributes to results visible after edge T+2.
- Last sample at edge T: DRAIN at T+1..T+2, done high T+3..T+4 window (one cycle), busy low with done.
- num_samples=0: start at T → done one cycle after 2-cycle DRAIN; all results 0.
- Throughput: one sample per cycle; in_valid gaps allowed anywhere.

## Configuration
- ADDER_ERR_BIAS_EN defined: adds output bias_sum (signed, ACC_W+1 bits, reset/start clear to 0) accumulating signed (approx_sum − exact_sum) in stage 2 without saturation (wraps, two's complement); enables mean-error-bias measurement.
- Undefined: port bias_sum absent; no signed datapath; all other behaviour identical.

## Test plan
- Reset then start, num_samples=4, pairs (5,5),(7,5),(5,9),(0xFFFF,0) back-to-back → sample_count=4, err_count=3, sum_ed=0xFFFF+6=65541, max_ed=0xFFFF, ovf=0, done single pulse.
- num_samples=3 with in_valid toggling 1,0,0,1,0,1 (all pairs equal) → 3 accepted, err_count=0, sum_ed=0, in_ready low after third transfer.
- ACC_W=17, N=16, num_samples=3, each pair (0xFFFF,0) → sum_ed=0x1FFFF, ovf=1, max_ed=0xFFFF.
- num_samples=0 → done after 3 cycles, all results 0; start pulsed during RUN of a 10-sample run → ignored, run completes with sample_count=10.
- rst_n low for one cycle after 2 of 5 samples → all outputs at reset values next cycle, FSM IDLE, no done pulse.
- With ADDER_ERR_BIAS_EN: pairs (7,5),(5,9) → bias_sum=−2; without it, build elaborates with no bias_sum port.

Source files
------------

// File: rtl/adder_error_monitor.sv
// adder_error_monitor
// Streaming error-metric engine for an N-bit approximate adder. Each accepted
// (approx_sum, exact_sum) pair flows through a two-stage pipeline: stage 1
// forms the unsigned error distance and mismatch flag, stage 2 folds them into
// the error count, the saturating total distance and the running maximum.
// A run covers a programmed number of samples and ends with a one-cycle done.
//
// Optional feature macro: ADDER_ERR_BIAS_EN
//   When defined, adds a signed, wrapping accumulator bias_sum of the signed
//   difference (approx_sum - exact_sum) for mean-error-bias measurement.
//   When undefined, the port and its signed datapath are absent.

module adder_error_monitor #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     approx_sum,
    input  logic [N-1:0]     exact_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N-1:0]     max_ed,
    output logic             ovf
`ifdef ADDER_ERR_BIAS_EN
    ,
    output logic signed [ACC_W:0] bias_sum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] num_lat;
    logic             drain_cnt;
    logic             start_ok;
    logic             xfer;
    logic             last_xfer;

    logic [N-1:0]     ed_next;
    logic             s1_valid;
    logic [N-1:0]     s1_ed;
    logic             s1_mismatch;
    logic [ACC_W:0]   sum_wide;

`ifdef ADDER_ERR_BIAS_EN
    logic signed [N:0] s1_diff;
`endif

    // Handshake and status decode; in_ready closes once the run quota is met
    always_comb begin
        start_ok  = (state == IDLE) && start;
        in_ready  = (state == RUN) && (sample_count < num_lat);
        xfer      = in_valid && in_ready;
        last_xfer = xfer && ((sample_count + CNT_W'(1)) == num_lat);
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
    end

    // Next-state logic; a zero-length run skips straight to the drain wait
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_samples == '0) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run control: latched quota, accepted-sample counter and two-cycle drain timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_lat      <= '0;
            sample_count <= '0;
            drain_cnt    <= 1'b0;
        end else begin
            if (start_ok) begin
                num_lat      <= num_samples;
                sample_count <= '0;
            end else if (xfer) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? 1'b1 : 1'b0;
        end
    end

    // Error distance as a true magnitude: subtract the smaller operand from the larger
    always_comb begin
        if (approx_sum >= exact_sum) begin
            ed_next = approx_sum - exact_sum;
        end else begin
            ed_next = exact_sum - approx_sum;
        end
    end

    // Stage 1: capture distance and mismatch for each accepted sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_ed       <= '0;
            s1_mismatch <= 1'b0;
        end else begin
            s1_valid    <= xfer;
            s1_ed       <= ed_next;
            s1_mismatch <= (approx_sum != exact_sum);
        end
    end

    // Widened sum so a carry out of the accumulator signals saturation
    always_comb begin
        sum_wide = {1'b0, sum_ed} + (ACC_W + 1)'(s1_ed);
    end

    // Stage 2: accumulate metrics; results hold until the next accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            ovf       <= 1'b0;
        end else if (start_ok) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            ovf       <= 1'b0;
        end else if (s1_valid) begin
            if (s1_mismatch) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (sum_wide[ACC_W]) begin
                sum_ed <= '1;
                ovf    <= 1'b1;
            end else begin
                sum_ed <= sum_wide[ACC_W-1:0];
            end
            if (s1_ed > max_ed) begin
                max_ed <= s1_ed;
            end
        end
    end

`ifdef ADDER_ERR_BIAS_EN
    // Signed difference for the bias path, one bit wider than the operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_diff <= '0;
        end else begin
            s1_diff <= $signed({1'b0, approx_sum}) - $signed({1'b0, exact_sum});
        end
    end

    // Wrapping two's-complement bias accumulator, cleared with the other results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_sum <= '0;
        end else if (start_ok) begin
            bias_sum <= '0;
        end else if (s1_valid) begin
            bias_sum <= bias_sum + (ACC_W + 1)'(s1_diff);
        end
    end
`endif

endmodule
